// File: rtl/dc_pkg.sv
// Shared constants and helpers for the dc_scan decoder family.
// Functions work on the widest supported index; callers size-cast to their own N.
package dc_pkg;

   localparam int DC_MAX_AW = 8;
   localparam int DC_MAX_N  = 1 << DC_MAX_AW;

   localparam logic DC_MODE_DIRECT = 1'b0;
   localparam logic DC_MODE_SCAN   = 1'b1;

   typedef struct packed {
      logic                 found;
      logic [DC_MAX_AW-1:0] idx;
   } dc_next_t;

   function automatic logic [DC_MAX_N-1:0] onehot(input logic [DC_MAX_AW-1:0] idx);
      logic [DC_MAX_N-1:0] r;
      r      = '0;
      r[idx] = 1'b1;
      return r;
   endfunction

   // First enabled channel cyclically after idx; idx itself is the last candidate.
   function automatic dc_next_t next_unmasked(input logic [DC_MAX_AW-1:0] idx,
                                              input logic [DC_MAX_N-1:0]  mask,
                                              input int                   n);
      dc_next_t r;
      int       j;
      r.found = 1'b0;
      r.idx   = idx;
      for (int k = 1; k <= DC_MAX_N; k++) begin
         j = (int'(idx) + k) % n;
         if (k <= n && !r.found && mask[j[DC_MAX_AW-1:0]]) begin
            r.found = 1'b1;
            r.idx   = j[DC_MAX_AW-1:0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/dc_prescaler.sv
// Step-tick generator: counts 0..DIV-1 while enabled and ticks on the last count.
module dc_prescaler #(
   parameter int DIV = 1000
) (
   input  logic iclk,
   input  logic irst_n,
   input  logic iclr,
   input  logic ien,
   output logic otick
);

   localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] r_cnt;

   // A clear wins over a tick so the first step is always DIV cycles away.
   assign otick = ien && !iclr && (r_cnt == LAST);

   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         r_cnt <= '0;
      end else if (iclr) begin
         r_cnt <= '0;
      end else if (ien) begin
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + PW'(1);
      end
   end

endmodule

// File: rtl/dc_scan.sv
// Registered one-hot decoder with direct and automatic scan modes.
// Define DC_SCAN_MASK_EN to add the per-channel imask port.
module dc_scan
   import dc_pkg::*;
#(
   parameter  int AW  = 2,
   parameter  int DIV = 1000,
   localparam int N   = 1 << AW
) (
   input  logic          iclk,
   input  logic          irst_n,
   input  logic [AW-1:0] ia,
   input  logic          is,
   input  logic          imode,
`ifdef DC_SCAN_MASK_EN
   input  logic [N-1:0]  imask,
`endif
   output logic [N-1:0]  oout,
   output logic [AW-1:0] oidx,
   output logic          ostep
);

   logic          r_mode;
   logic          w_entry;
   logic          w_en;
   logic          w_clr;
   logic          w_tick;
   logic          w_next_ok;
   logic [AW-1:0] w_next_idx;
   logic [N-1:0]  w_mask;
   logic [N-1:0]  w_dir_oh;
   logic [N-1:0]  w_next_oh;

   assign w_en    = is && (imode == DC_MODE_SCAN);
   assign w_entry = w_en && (r_mode == DC_MODE_DIRECT);
   assign w_clr   = !w_en || w_entry;

   dc_prescaler #(
      .DIV (DIV)
   ) u_prescaler (
      .iclk   (iclk),
      .irst_n (irst_n),
      .iclr   (w_clr),
      .ien    (w_en),
      .otick  (w_tick)
   );

`ifdef DC_SCAN_MASK_EN
   dc_next_t w_nxt;
   assign w_mask     = imask;
   assign w_nxt      = next_unmasked(DC_MAX_AW'(oidx), DC_MAX_N'(imask), N);
   assign w_next_ok  = w_nxt.found;
   assign w_next_idx = AW'(w_nxt.idx);
`else
   assign w_mask     = '1;
   assign w_next_ok  = 1'b1;
   assign w_next_idx = oidx + AW'(1);
`endif

   assign w_dir_oh  = N'(onehot(DC_MAX_AW'(ia))) & w_mask;
   assign w_next_oh = N'(onehot(DC_MAX_AW'(w_next_idx)));

   // r_mode tracks imode even while disabled, so re-enabling in scan resumes rather than restarts.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         r_mode <= DC_MODE_DIRECT;
         oout   <= '0;
         oidx   <= '0;
         ostep  <= 1'b0;
      end else begin
         r_mode <= imode;
         if (!is) begin
            oout  <= '0;
            ostep <= 1'b0;
         end else if (imode == DC_MODE_DIRECT) begin
            oidx  <= ia;
            oout  <= w_dir_oh;
            ostep <= 1'b0;
         end else if (w_entry) begin
            oidx  <= '0;
            oout  <= N'(1);
            ostep <= 1'b0;
         end else if (w_tick) begin
            ostep <= 1'b1;
            if (w_next_ok) begin
               oidx <= w_next_idx;
               oout <= w_next_oh;
            end else begin
               oout <= '0;
            end
         end else begin
            ostep <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dc_scan.sv
// Scoreboard bench for dc_scan: one instance with DIV=4, one with DIV=1.
module tb_dc_scan;

   typedef struct {
      logic [3:0] o;
      logic [1:0] i;
      logic       s;
   } exp_t;

   exp_t q4[$];
   exp_t q1[$];
   int   nvec = 0;
   int   nmis = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst4 = 1'b0, s4 = 1'b0, m4 = 1'b0;
   logic [1:0] a4 = '0;
   logic       rst1 = 1'b0, s1 = 1'b0, m1 = 1'b0;
   logic [1:0] a1 = '0;
   logic [3:0] o4, o1;
   logic [1:0] i4, i1;
   logic       st4, st1;
`ifdef DC_SCAN_MASK_EN
   logic [3:0] mask4 = 4'b1111;
   logic [3:0] mask1 = 4'b1111;
`endif

   dc_scan #(.AW(2), .DIV(4)) u_dut4 (
      .iclk   (clk),
      .irst_n (rst4),
      .ia     (a4),
      .is     (s4),
      .imode  (m4),
`ifdef DC_SCAN_MASK_EN
      .imask  (mask4),
`endif
      .oout   (o4),
      .oidx   (i4),
      .ostep  (st4)
   );

   dc_scan #(.AW(2), .DIV(1)) u_dut1 (
      .iclk   (clk),
      .irst_n (rst1),
      .ia     (a1),
      .is     (s1),
      .imode  (m1),
`ifdef DC_SCAN_MASK_EN
      .imask  (mask1),
`endif
      .oout   (o1),
      .oidx   (i1),
      .ostep  (st1)
   );

   function automatic exp_t mk(input logic [3:0] o, input logic [1:0] i, input logic s);
      exp_t e;
      e.o = o;
      e.i = i;
      e.s = s;
      return e;
   endfunction

   task automatic chk(input string nm, input exp_t e,
                      input logic [3:0] o, input logic [1:0] i, input logic s);
      nvec++;
      if (o !== e.o || i !== e.i || s !== e.s) begin
         nmis++;
         $display("FAIL %s vec %0d: got oout=%b oidx=%0d ostep=%b, want oout=%b oidx=%0d ostep=%b",
                  nm, nvec, o, i, s, e.o, e.i, e.s);
      end
   endtask

   always @(negedge clk) begin
      if (q4.size() > 0) chk("div4", q4.pop_front(), o4, i4, st4);
      if (q1.size() > 0) chk("div1", q1.pop_front(), o1, i1, st1);
   end

   task automatic cyc4(input logic s, input logic m, input logic [1:0] a,
                       input logic [3:0] eo, input logic [1:0] ei, input logic es);
      s4 = s; m4 = m; a4 = a;
      @(posedge clk); #1;
      q4.push_back(mk(eo, ei, es));
   endtask

   task automatic cyc1(input logic s, input logic m, input logic [1:0] a,
                       input logic [3:0] eo, input logic [1:0] ei, input logic es);
      s1 = s; m1 = m; a1 = a;
      @(posedge clk); #1;
      q1.push_back(mk(eo, ei, es));
   endtask

   // Three idle cycles holding the previous channel, then the step onto the new one.
   task automatic step4(input logic [3:0] po, input logic [1:0] pi,
                        input logic [3:0] no, input logic [1:0] ni);
      repeat (3) cyc4(1'b1, 1'b1, 2'd0, po, pi, 1'b0);
      cyc4(1'b1, 1'b1, 2'd0, no, ni, 1'b1);
   endtask

   initial begin
      @(posedge clk); #1;
      q4.push_back(mk(4'b0000, 2'd0, 1'b0));
      q1.push_back(mk(4'b0000, 2'd0, 1'b0));
      rst4 = 1'b1;

      // direct mode and disable
      cyc4(1'b1, 1'b0, 2'd2, 4'b0100, 2'd2, 1'b0);
      cyc4(1'b0, 1'b0, 2'd2, 4'b0000, 2'd2, 1'b0);
      cyc4(1'b1, 1'b0, 2'd3, 4'b1000, 2'd3, 1'b0);
      cyc4(1'b1, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b0);

      // scan entry and full cycle 0,1,2,3,0
      cyc4(1'b1, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b0);
      step4(4'b0001, 2'd0, 4'b0010, 2'd1);
      step4(4'b0010, 2'd1, 4'b0100, 2'd2);
      step4(4'b0100, 2'd2, 4'b1000, 2'd3);
      step4(4'b1000, 2'd3, 4'b0001, 2'd0);
      step4(4'b0001, 2'd0, 4'b0010, 2'd1);
      step4(4'b0010, 2'd1, 4'b0100, 2'd2);
      step4(4'b0100, 2'd2, 4'b1000, 2'd3);
      cyc4(1'b1, 1'b1, 2'd0, 4'b1000, 2'd3, 1'b0);

      // reset asserted at oidx=3, prescaler=2
      @(posedge clk); #1;
      rst4 = 1'b0;
      #1;
      q4.push_back(mk(4'b0000, 2'd0, 1'b0));
      cyc4(1'b1, 1'b1, 2'd0, 4'b0000, 2'd0, 1'b0);
      rst4 = 1'b1;
      cyc4(1'b1, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b0);
      step4(4'b0001, 2'd0, 4'b0010, 2'd1);
      step4(4'b0010, 2'd1, 4'b0100, 2'd2);

      // scan to direct in mid-step
      cyc4(1'b1, 1'b1, 2'd0, 4'b0100, 2'd2, 1'b0);
      cyc4(1'b1, 1'b0, 2'd1, 4'b0010, 2'd1, 1'b0);
      repeat (4) cyc4(1'b1, 1'b0, 2'd1, 4'b0010, 2'd1, 1'b0);

`ifdef DC_SCAN_MASK_EN
      mask4 = 4'b1010;
      cyc4(1'b1, 1'b0, 2'd2, 4'b0000, 2'd2, 1'b0);
      cyc4(1'b1, 1'b0, 2'd3, 4'b1000, 2'd3, 1'b0);
      cyc4(1'b1, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b0);
      step4(4'b0001, 2'd0, 4'b0010, 2'd1);
      step4(4'b0010, 2'd1, 4'b1000, 2'd3);
      step4(4'b1000, 2'd3, 4'b0010, 2'd1);
      step4(4'b0010, 2'd1, 4'b1000, 2'd3);
      mask4 = 4'b0000;
      step4(4'b1000, 2'd3, 4'b0000, 2'd3);
      step4(4'b0000, 2'd3, 4'b0000, 2'd3);
`endif

      // DIV=1: continuous stepping, pause, resume from frozen index
      rst1 = 1'b1;
      cyc1(1'b1, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b0);
      cyc1(1'b1, 1'b1, 2'd0, 4'b0010, 2'd1, 1'b1);
      cyc1(1'b1, 1'b1, 2'd0, 4'b0100, 2'd2, 1'b1);
      cyc1(1'b1, 1'b1, 2'd0, 4'b1000, 2'd3, 1'b1);
      cyc1(1'b1, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b1);
      cyc1(1'b1, 1'b1, 2'd0, 4'b0010, 2'd1, 1'b1);
      repeat (3) cyc1(1'b0, 1'b1, 2'd0, 4'b0000, 2'd1, 1'b0);
      cyc1(1'b1, 1'b1, 2'd0, 4'b0100, 2'd2, 1'b1);
      cyc1(1'b1, 1'b1, 2'd0, 4'b1000, 2'd3, 1'b1);
      cyc1(1'b1, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b1);

      repeat (2) @(posedge clk);
      #1;
      if (q4.size() + q1.size() != 0) begin
         nmis++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", q4.size() + q1.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
